// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp encodings and phase timing helpers for the
// two-road intersection sequencer.
package traffic_pkg;

    typedef logic [2:0] phase_t;
    typedef logic [2:0] light_t;

    localparam phase_t NS_GREEN  = 3'd0;
    localparam phase_t NS_YELLOW = 3'd1;
    localparam phase_t ALL_RED_A = 3'd2;
    localparam phase_t EW_GREEN  = 3'd3;
    localparam phase_t EW_YELLOW = 3'd4;
    localparam phase_t ALL_RED_B = 3'd5;

    // Lamp bits are {red, yellow, green}.
    localparam light_t RED = 3'b100;
    localparam light_t YEL = 3'b010;
    localparam light_t GRN = 3'b001;

    function automatic int unsigned phase_duration(
        input phase_t      p,
        input int unsigned green_s,
        input int unsigned yellow_s,
        input int unsigned all_red_s
    );
        int unsigned d;
        case (p)
            NS_GREEN, EW_GREEN:   d = green_s;
            NS_YELLOW, EW_YELLOW: d = yellow_s;
            default:              d = all_red_s;
        endcase
        return d;
    endfunction

    function automatic phase_t next_phase(input phase_t p);
        phase_t n;
        case (p)
            NS_GREEN:  n = NS_YELLOW;
            NS_YELLOW: n = ALL_RED_A;
            ALL_RED_A: n = EW_GREEN;
            EW_GREEN:  n = EW_YELLOW;
            EW_YELLOW: n = ALL_RED_B;
            default:   n = NS_GREEN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable seconds down-counter; last flags the final second of a phase.
module phase_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    // NOTE: no reset of its own; the owner asserts load during reset, so the
    // count is defined from the first reset edge without a second reset path.
    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_value;
        end else if (dec) begin
            count <= count - CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-road light sequencer: steps NS/EW phases on one-second ticks, holds NS
// green until an EW request is latched, and restarts the divider on each phase.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_S   = 20,
    parameter int unsigned YELLOW_S  = 3,
    parameter int unsigned ALL_RED_S = 1,
    parameter int unsigned CNT_W     = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sec_tick,
    input  logic             ew_car,
    output logic             devider_reset,
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] secs_left
);

    phase_t           state_q;
    phase_t           next_state;
    phase_t           load_phase;
    light_t           ns_next;
    light_t           ew_next;
    logic             ew_req;
    logic             valid_tick;
    logic             last;
    logic             entry;
    logic [CNT_W-1:0] load_value;

    // A tick arriving while the divider is being restarted belongs to the old phase.
    assign valid_tick = sec_tick && !devider_reset;
    assign entry      = (next_state != state_q);
    assign load_phase = reset ? ALL_RED_B : next_state;
    assign load_value = CNT_W'(phase_duration(load_phase, GREEN_S, YELLOW_S, ALL_RED_S));
    assign phase      = state_q;

    phase_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk       (clk),
        .load      (reset || entry),
        .load_value(load_value),
        .dec       (valid_tick && !last),
        .count     (secs_left),
        .last      (last)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ALL_RED_B;
            devider_reset <= 1'b1;
            ns_light      <= RED;
            ew_light      <= RED;
            ew_req        <= 1'b0;
        end else begin
            state_q       <= next_state;
            devider_reset <= entry;
            ns_light      <= ns_next;
            ew_light      <= ew_next;
            if (entry && next_state == EW_GREEN) begin
                ew_req <= 1'b0;
            end else if (ew_car) begin
                ew_req <= 1'b1;
            end
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state_q;
        case (state_q)
            NS_GREEN: begin
                if (valid_tick && last && ew_req) next_state = NS_YELLOW;
            end
            NS_YELLOW, ALL_RED_A, EW_GREEN, EW_YELLOW, ALL_RED_B: begin
                if (valid_tick && last) next_state = next_phase(state_q);
            end
            default: next_state = ALL_RED_B;
        endcase
    end

    // Lamps are registered from the phase being entered so they move with phase.
    always_comb begin
        ns_next = RED;
        ew_next = RED;
        case (next_state)
            NS_GREEN:  ns_next = GRN;
            NS_YELLOW: ns_next = YEL;
            EW_GREEN:  ew_next = GRN;
            EW_YELLOW: ew_next = YEL;
            default:   ;
        endcase
    end

endmodule
